// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state encoding
// and the sequential PC step.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_timeout_cntr.sv
// Wait counter for outstanding fetches; expired flags the last permitted
// ack-less cycle so the controller can fault on that edge.
module fetch_timeout_cntr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // The count never needs to pass TIMEOUT-1: the controller leaves REQ when expired fires.
  always_comb begin
    count_d = count_q;
    expired = enable && (count_q == CW'(TIMEOUT - 1));
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Single-outstanding instruction fetch controller with redirect handling,
// a bounded wait for memory and a sticky fault state.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter int unsigned                INSTR_WIDTH   = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
  parameter int unsigned                TIMEOUT       = 15
) (
  input  logic                     clk,
  input  logic                     n_reset,
  output logic                     mem_req,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic                     mem_ack,
  input  logic [INSTR_WIDTH-1:0]   mem_rdata,
  output logic                     instr_valid,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     fetch_fault
);

  fetch_state_e             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                     redirect_aligned;
  logic                     tmo_clear;
  logic                     tmo_enable;
  logic                     tmo_expired;

  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

  // Redirect outranks both a same-cycle ack and a same-cycle handshake.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        pc_d    = RESET_PC;
      end
      REQ: begin
        if (redirect) begin
          if (redirect_aligned) begin
            pc_d    = redirect_pc;
            state_d = REQ;
          end else begin
            state_d = FAULT;
          end
        end else if (mem_ack) begin
          instr_d    = mem_rdata;
          instr_pc_d = pc_q;
          state_d    = HOLD;
        end else if (tmo_expired) begin
          state_d = FAULT;
        end
      end
      HOLD: begin
        if (redirect) begin
          if (redirect_aligned) begin
            pc_d    = redirect_pc;
            state_d = REQ;
          end else begin
            state_d = FAULT;
          end
        end else if (instr_ready) begin
          pc_d    = pc_q + ADDRESS_WIDTH'(PC_INC);
          state_d = REQ;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter sits at zero outside REQ and restarts on a redirected refetch.
  assign tmo_clear  = (state_q != REQ) || redirect;
  assign tmo_enable = (state_q == REQ) && !mem_ack;

  fetch_timeout_cntr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .n_reset (n_reset),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign mem_req     = (state_q == REQ);
  assign mem_addr    = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_fault = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed vector table, timeout
// sequences and randomized traffic checked against a behavioural model.
module tb_fetch_controller;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        n_rst;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_addr_chk;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_fault;
  } vec_t;

  vec_t tbl[$];

  bit          m_idle;
  bit          m_fault;
  bit          m_valid;
  longint      m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  int          m_wait;

  fetch_controller dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic vec_t row(input logic n_rst, input logic ack, input logic [31:0] rdata,
                               input logic ready, input logic redir, input logic [31:0] rpc,
                               input logic e_req, input logic [31:0] e_addr, input logic e_addr_chk,
                               input logic e_valid, input logic [31:0] e_instr,
                               input logic [31:0] e_ipc, input logic e_fault);
    vec_t v;
    v.n_rst = n_rst; v.ack = ack; v.rdata = rdata; v.ready = ready;
    v.redir = redir; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
    v.e_addr_chk = e_addr_chk; v.e_valid = e_valid; v.e_instr = e_instr;
    v.e_ipc = e_ipc; v.e_fault = e_fault;
    return v;
  endfunction

  function automatic vec_t stim(input logic n_rst, input logic ack, input logic [31:0] rdata,
                                input logic ready, input logic redir, input logic [31:0] rpc);
    return row(n_rst, ack, rdata, ready, redir, rpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model view: one fetch in flight or one instruction held, plus a sticky fault.
  task automatic modelUpdate(input vec_t v);
    if (!v.n_rst) begin
      m_idle = 1; m_fault = 0; m_valid = 0; m_pc = 0; m_wait = 0;
      m_instr = 32'h0; m_ipc = 32'h0;
    end else if (m_fault) begin
    end else if (m_idle) begin
      m_idle = 0; m_pc = 0; m_wait = 0;
    end else if (v.redir) begin
      if (v.rpc % 4 != 0) begin
        m_fault = 1; m_valid = 0;
      end else begin
        m_pc = v.rpc; m_valid = 0; m_wait = 0;
      end
    end else if (m_valid) begin
      if (v.ready) begin
        m_valid = 0; m_pc = (m_pc + 4) % 64'h1_0000_0000; m_wait = 0;
      end
    end else if (v.ack) begin
      m_instr = v.rdata; m_ipc = 32'(m_pc); m_valid = 1;
    end else begin
      m_wait++;
      if (m_wait == TIMEOUT) m_fault = 1;
    end
  endtask

  task automatic modelCheck();
    chk("model_mem_req", mem_req, !m_idle && !m_fault && !m_valid);
    if (!m_fault) chk("model_mem_addr", mem_addr, 32'(m_pc));
    chk("model_instr_valid", instr_valid, m_valid);
    chk("model_instr", instr, m_instr);
    chk("model_instr_pc", instr_pc, m_ipc);
    chk("model_fetch_fault", fetch_fault, m_fault);
  endtask

  task automatic applyStimulus(input vec_t v);
    n_reset     = v.n_rst;
    mem_ack     = v.ack;
    mem_rdata   = v.rdata;
    instr_ready = v.ready;
    redirect    = v.redir;
    redirect_pc = v.rpc;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string s;
    s = $sformatf("row%0d", idx);
    chk({s, "_mem_req"}, mem_req, v.e_req);
    if (v.e_addr_chk) chk({s, "_mem_addr"}, mem_addr, v.e_addr);
    chk({s, "_instr_valid"}, instr_valid, v.e_valid);
    chk({s, "_instr"}, instr, v.e_instr);
    chk({s, "_instr_pc"}, instr_pc, v.e_ipc);
    chk({s, "_fetch_fault"}, fetch_fault, v.e_fault);
  endtask

  // Called with clk low: compare the settled outputs, drive, clock, advance the model.
  task automatic step(input vec_t v, input bit chk_model);
    if (chk_model) modelCheck();
    applyStimulus(v);
    @(posedge clk);
    modelUpdate(v);
    @(negedge clk);
  endtask

  task automatic resetToReq();
    step(stim(0, 0, 0, 0, 0, 0), 1);
    step(stim(0, 0, 0, 0, 0, 0), 1);
    step(stim(1, 0, 0, 0, 0, 0), 1);
  endtask

  initial begin
    vec_t v;
    logic [31:0] r;

    tbl.push_back(row(1,0,32'h0,0,0,32'h0,            0,32'h0,1,0,32'h0,32'h0,0));
    tbl.push_back(row(1,0,32'h0,0,0,32'h0,            1,32'h0,1,0,32'h0,32'h0,0));
    tbl.push_back(row(1,1,32'h00500093,0,0,32'h0,     1,32'h0,1,0,32'h0,32'h0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(row(1,0,32'h0,0,0,32'h0,          0,32'h0,1,1,32'h00500093,32'h0,0));
    tbl.push_back(row(1,0,32'h0,1,0,32'h0,            0,32'h0,1,1,32'h00500093,32'h0,0));
    tbl.push_back(row(1,1,32'h11111111,0,1,32'h100,   1,32'h4,1,0,32'h00500093,32'h0,0));
    tbl.push_back(row(1,1,32'h22222222,0,0,32'h0,     1,32'h100,1,0,32'h00500093,32'h0,0));
    tbl.push_back(row(1,0,32'h0,1,1,32'h200,          0,32'h100,1,1,32'h22222222,32'h100,0));
    tbl.push_back(row(1,0,32'h0,0,1,32'hFFFFFFFC,     1,32'h200,1,0,32'h22222222,32'h100,0));
    tbl.push_back(row(1,1,32'h33333333,0,0,32'h0,     1,32'hFFFFFFFC,1,0,32'h22222222,32'h100,0));
    tbl.push_back(row(1,0,32'h0,1,0,32'h0,            0,32'hFFFFFFFC,1,1,32'h33333333,32'hFFFFFFFC,0));
    tbl.push_back(row(1,0,32'h0,0,1,32'h102,          1,32'h0,1,0,32'h33333333,32'hFFFFFFFC,0));
    tbl.push_back(row(1,1,32'h44444444,1,1,32'h40,    0,32'h0,0,0,32'h33333333,32'hFFFFFFFC,1));
    tbl.push_back(row(1,1,32'h0,1,0,32'h0,            0,32'h0,0,0,32'h33333333,32'hFFFFFFFC,1));
    tbl.push_back(row(0,1,32'h55555555,0,0,32'h0,     0,32'h0,0,0,32'h33333333,32'hFFFFFFFC,1));
    tbl.push_back(row(1,1,32'h66666666,1,0,32'h0,     0,32'h0,1,0,32'h0,32'h0,0));
    tbl.push_back(row(1,0,32'h0,0,0,32'h0,            1,32'h0,1,0,32'h0,32'h0,0));
    tbl.push_back(row(0,1,32'h77777777,0,0,32'h0,     1,32'h0,1,0,32'h0,32'h0,0));
    tbl.push_back(row(1,1,32'h88888888,0,0,32'h0,     0,32'h0,1,0,32'h0,32'h0,0));
    tbl.push_back(row(1,0,32'h0,0,0,32'h0,            1,32'h0,1,0,32'h0,32'h0,0));

    applyStimulus(stim(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    step(stim(0, 0, 0, 0, 0, 0), 0);
    step(stim(0, 0, 0, 0, 0, 0), 0);

    foreach (tbl[i]) begin
      checkOutput(tbl[i], i);
      step(tbl[i], 1);
    end

    // Fourteen silent REQ cycles are tolerated; the fifteenth faults.
    resetToReq();
    for (int i = 0; i < TIMEOUT - 1; i++) step(stim(1, 0, 0, 0, 0, 0), 1);
    chk("tmo_pre_fault", fetch_fault, 1'b0);
    chk("tmo_pre_req", mem_req, 1'b1);
    step(stim(1, 0, 0, 0, 0, 0), 1);
    chk("tmo_fault", fetch_fault, 1'b1);
    chk("tmo_req_off", mem_req, 1'b0);
    step(stim(1, 1, 32'h12345678, 1, 1, 32'h80), 1);
    chk("tmo_fault_sticky", fetch_fault, 1'b1);

    resetToReq();
    for (int i = 0; i < TIMEOUT - 1; i++) step(stim(1, 0, 0, 0, 0, 0), 1);
    step(stim(1, 1, 32'hABCD0013, 0, 0, 0), 1);
    chk("late_ack_valid", instr_valid, 1'b1);
    chk("late_ack_instr", instr, 32'hABCD0013);
    chk("late_ack_fault", fetch_fault, 1'b0);

    resetToReq();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom();
      if ($urandom_range(99) < 85) r[1:0] = 2'b00;
      v = stim($urandom_range(99) >= 2, $urandom_range(99) < 40, $urandom(),
               $urandom_range(99) < 50, $urandom_range(99) < 8, r);
      step(v, 1);
    end
    modelCheck();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
